// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: writeback result-source encoding and register-file sizing.
package rv32_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  localparam int          REG_COUNT = 32;
  localparam logic [4:0]  X0        = 5'd0;

endpackage

// File: rtl/writeback_regfile_reg_file.sv
// Integer register array with synchronous reset/write, two asynchronous read ports with
// same-cycle write-through bypass, and a debug tap on one register.
module reg_file
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEBUG_REG  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr1,
  input  logic [ADDR_WIDTH-1:0] i_raddr2,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [DATA_WIDTH-1:0] o_rdata2,
  output logic [DATA_WIDTH-1:0] o_dbg
);

  localparam int                    NREGS   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DEBUG_REG);

  logic [DATA_WIDTH-1:0] r_regs [NREGS];
  logic                  w_commit;

  assign w_commit = i_we && (i_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // x0 reads zero even when a write to it is being presented on the bypass.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    if (addr == '0)                    return '0;
    else if (i_we && i_waddr == addr)  return i_wdata;
    else                               return r_regs[addr];
  endfunction

  assign o_rdata1 = read_port(i_raddr1);
  assign o_rdata2 = read_port(i_raddr2);
  assign o_dbg    = r_regs[DBG_IDX];

endmodule

// File: rtl/writeback_regfile.sv
// RV32I writeback stage: selects the architectural result, commits it to the register file,
// and counts committed non-x0 writes.
module writeback_regfile
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEBUG_REG  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResultW,
  input  logic [DATA_WIDTH-1:0] ReadDataW,
  input  logic [DATA_WIDTH-1:0] PCPlus4W,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcW,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  output logic [DATA_WIDTH-1:0] RD1D,
  output logic [DATA_WIDTH-1:0] RD2D,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [DATA_WIDTH-1:0] WbCount
);

  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH-1:0] r_wb_count;
  logic                  w_commit;

  // The reserved encoding 2'b11 falls back to the ALU result.
  always_comb begin
    w_result = ALUResultW;
    case (ResultSrcW)
      RES_MEM: w_result = ReadDataW;
      RES_PC4: w_result = PCPlus4W;
      default: w_result = ALUResultW;
    endcase
  end

  assign w_commit = RegWriteW && (RdW != '0);

  always_ff @(posedge clk) begin
    if (rst)           r_wb_count <= '0;
    else if (w_commit) r_wb_count <= r_wb_count + 1'b1;
  end

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEBUG_REG  (DEBUG_REG)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_we     (RegWriteW),
    .i_waddr  (RdW),
    .i_wdata  (w_result),
    .i_raddr1 (Rs1D),
    .i_raddr2 (Rs2D),
    .o_rdata1 (RD1D),
    .o_rdata2 (RD2D),
    .o_dbg    (a0)
  );

  assign ResultW = w_result;
  assign WbCount = r_wb_count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized bench for writeback_regfile against an array-based reference model.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] RD1D, RD2D, ResultW, a0, WbCount;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  writeback_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .ResultW    (ResultW),
    .a0         (a0),
    .WbCount    (WbCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_result();
    if (ResultSrcW == 2'b01)      return ReadDataW;
    else if (ResultSrcW == 2'b10) return PCPlus4W;
    else                          return ALUResultW;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] rs);
    if (rs == 5'd0)                      return 32'd0;
    else if (RegWriteW && RdW == rs)     return exp_result();
    else                                 return m_regs[rs];
  endfunction

  // One clock: drive inputs, check combinational outputs at the falling edge,
  // then advance the model across the rising edge.
  task automatic step(input logic r, input logic we, input logic [4:0] rd, input logic [1:0] src,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                      input logic [4:0] rs1, input logic [4:0] rs2, input string tag);
    rst = r; RegWriteW = we; RdW = rd; ResultSrcW = src;
    ALUResultW = alu; ReadDataW = mem; PCPlus4W = pc4; Rs1D = rs1; Rs2D = rs2;
    @(negedge clk);
    chk({tag, ".ResultW"}, ResultW, exp_result());
    chk({tag, ".RD1D"},    RD1D,    exp_read(rs1));
    chk({tag, ".RD2D"},    RD2D,    exp_read(rs2));
    chk({tag, ".a0"},      a0,      m_regs[10]);
    chk({tag, ".WbCount"}, WbCount, m_cnt);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (we && rd != 5'd0) begin
      m_regs[rd] = exp_result();
      m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic idle_read(input logic [4:0] rs1, input logic [4:0] rs2, input string tag);
    step(1'b0, 1'b0, 5'd0, 2'b00, $urandom, $urandom, $urandom, rs1, rs2, tag);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
    rst = 1'b1; RegWriteW = 1'b0; RdW = '0; ResultSrcW = '0;
    ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0; Rs1D = '0; Rs2D = '0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 5'd0, 2'b00, 0, 0, 0, 5'd0, 5'd0, "init_rst");

    // Random writes, then a 2-cycle reset clears everything.
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 5'($urandom_range(1, 31)), 2'($urandom), $urandom, $urandom, $urandom,
           5'($urandom), 5'($urandom), "fill");
    step(1'b1, 1'b0, 5'd0, 2'b00, 0, 0, 0, 5'd0, 5'd0, "rst_a");
    step(1'b1, 1'b0, 5'd0, 2'b00, 0, 0, 0, 5'd0, 5'd0, "rst_b");
    for (int i = 0; i < 32; i += 2) begin
      idle_read(5'(i), 5'(i + 1), "post_rst");
      chk("post_rst.rd1_zero", RD1D, 32'd0);
    end
    chk("post_rst.a0", a0, 32'd0);
    chk("post_rst.cnt", WbCount, 32'd0);

    // ALU result to x5 with same-cycle bypass, then from the array.
    step(1'b0, 1'b1, 5'd5, 2'b00, 32'h0000_1234, 0, 0, 5'd5, 5'd0, "byp_x5");
    idle_read(5'd5, 5'd5, "arr_x5");
    chk("x5_literal", RD1D, 32'h0000_1234);
    chk("cnt_one", WbCount, 32'd1);

    // Writes to x0 are dropped and not counted.
    step(1'b0, 1'b1, 5'd0, 2'b01, 0, 32'hDEAD_BEEF, 0, 5'd0, 5'd0, "x0_wr");
    idle_read(5'd0, 5'd0, "x0_rd");
    chk("x0_cnt", WbCount, 32'd1);

    // PC+4 link value and reserved select.
    step(1'b0, 1'b1, 5'd1, 2'b10, 32'd9, 32'd8, 32'h0000_0104, 5'd1, 5'd2, "pc4_x1");
    chk("pc4_result", ResultW, 32'h0000_0104);
    step(1'b0, 1'b1, 5'd2, 2'b11, 32'd7, 32'd5, 32'd6, 5'd1, 5'd2, "sel11");
    chk("sel11_result", ResultW, 32'd7);
    chk("x1_literal", RD1D, 32'h0000_0104);

    // Load into a0 with both ports bypassing.
    step(1'b0, 1'b1, 5'd10, 2'b01, 0, 32'hFFFF_FF80, 0, 5'd10, 5'd10, "a0_byp");
    chk("a0_byp_rd2", RD2D, 32'hFFFF_FF80);
    idle_read(5'd10, 5'd3, "a0_arr");
    chk("a0_literal", a0, 32'hFFFF_FF80);

    // Commit coincident with reset is dropped.
    step(1'b1, 1'b1, 5'd3, 2'b00, 32'h55, 0, 0, 5'd3, 5'd0, "rst_commit");
    idle_read(5'd3, 5'd10, "after_rst_commit");
    chk("x3_zero", RD1D, 32'd0);
    chk("cnt_zero", WbCount, 32'd0);

    // Counter wraps to zero.
    dut.r_wb_count = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step(1'b0, 1'b1, 5'd7, 2'b00, 32'h1, 0, 0, 5'd7, 5'd0, "wrap");
    idle_read(5'd7, 5'd0, "wrap_after");
    chk("wrap_cnt", WbCount, 32'd0);

    // Randomized traffic, including occasional resets and x0 destinations.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), rd, 2'($urandom),
           $urandom, $urandom, $urandom,
           ($urandom_range(0, 2) == 0) ? rd : 5'($urandom),
           ($urandom_range(0, 2) == 0) ? rd : 5'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
